aec_result_fmt: RTL and testbench

- Downstream stage of the arithmetic expression calculator. It consumes each single-cycle `valid`/`result[6:0]` pulse and turns the value into a decimal ASCII character stream, ending with a terminator character.
- Output uses a valid/ready byte handshake toward a display or serial sink.
- A small result FIFO absorbs back-to-back results while the sink applies backpressure.

---
 rtl/aec_result_fmt_pkg.sv | 41 ++++
 rtl/aec_result_fmt_if.sv | 23 ++
 rtl/aec_result_fmt_bin2bcd.sv | 59 +++++
 rtl/aec_result_fmt.sv | 171 +++++++++++++++++
 tb/tb_aec_result_fmt.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/aec_result_fmt_pkg.sv
// Shared types and constants for the result formatter: FSM states, ASCII codes
// and the digit helpers used while emitting a number.
package aec_pkg;

    localparam int AEC_RES_W = 7;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_EMIT,
        ST_TERM
    } aec_state_e;

    // Emit slot index: 0 = sign, 1 = hundreds, 2 = tens, 3 = ones.
    function automatic logic [1:0] first_digit(input logic [3:0] hundreds,
                                               input logic [3:0] tens);
        if (hundreds != 4'd0)
            return 2'd1;
        else if (tens != 4'd0)
            return 2'd2;
        else
            return 2'd3;
    endfunction

    function automatic logic [7:0] slot_char(input logic [1:0] idx,
                                             input logic [3:0] hundreds,
                                             input logic [3:0] tens,
                                             input logic [3:0] ones);
        case (idx)
            2'd0:    return ASCII_MINUS;
            2'd1:    return ASCII_ZERO + {4'h0, hundreds};
            2'd2:    return ASCII_ZERO + {4'h0, tens};
            default: return ASCII_ZERO + {4'h0, ones};
        endcase
    endfunction

endpackage

// File: rtl/aec_result_fmt_if.sv
// Result-in / character-out bundle of the formatter; the master side is the
// producer of results and consumer of characters.
interface aec_result_fmt_if;
    import aec_pkg::*;

    logic                 in_valid;
    logic [AEC_RES_W-1:0] in_result;
    logic                 out_ready;
    logic                 out_valid;
    logic [7:0]           out_char;
    logic                 busy;
    logic                 overflow;

    modport master (
        output in_valid, in_result, out_ready,
        input  out_valid, out_char, busy, overflow
    );

    modport slave (
        input  in_valid, in_result, out_ready,
        output out_valid, out_char, busy, overflow
    );
endinterface

// File: rtl/aec_result_fmt_bin2bcd.sv
// Iterative double-dabble: one add-3 + shift per cycle, seven cycles per value.
// done is high during the final step and the digit outputs already carry the result.
module aec_bin2bcd
    import aec_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AEC_RES_W-1:0] bin,
    output logic                 done,
    output logic [3:0]           hundreds,
    output logic [3:0]           tens,
    output logic [3:0]           ones
);

    logic [11:0]          bcd;
    logic [AEC_RES_W-1:0] src;
    logic [2:0]           steps_left;
    logic                 running;
    logic [11:0]          bcd_adj;
    logic [11:0]          bcd_step;
    logic [11:0]          bcd_out;

    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < 3; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5)
                bcd_adj[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
        end
        bcd_step = {bcd_adj[10:0], src[AEC_RES_W-1]};
        bcd_out  = running ? bcd_step : bcd;
    end

    assign done     = running && (steps_left == 3'd1);
    assign hundreds = bcd_out[11:8];
    assign tens     = bcd_out[7:4];
    assign ones     = bcd_out[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd        <= '0;
            src        <= '0;
            steps_left <= '0;
            running    <= 1'b0;
        end else if (start) begin
            bcd        <= '0;
            src        <= bin;
            steps_left <= 3'(AEC_RES_W);
            running    <= 1'b1;
        end else if (running) begin
            bcd        <= bcd_step;
            src        <= {src[AEC_RES_W-2:0], 1'b0};
            steps_left <= steps_left - 3'd1;
            if (steps_left == 3'd1)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/aec_result_fmt.sv
// Turns calculator results into a decimal ASCII stream with a terminator byte.
// Define AEC_FMT_SIGNED_EN to treat results as two's complement and emit '-'.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | waiting; pops the FIFO head into the converter when non-empty
//   CONV    | double-dabble running (7 cycles)
//   EMIT    | presenting sign/digit bytes, most significant first
//   TERM    | presenting TERM_CHAR; back to IDLE once accepted
module aec_result_fmt
    import aec_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] TERM_CHAR  = ASCII_LF
)
(
    input  logic             clk,
    input  logic             rst,
    aec_result_fmt_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [AEC_RES_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 overflow_r;

    aec_state_e           state;
    logic                 out_valid_r;
    logic [7:0]           out_char_r;
    logic                 neg_r;
    logic [1:0]           idx;
    logic [3:0]           dig_h;
    logic [3:0]           dig_t;
    logic [3:0]           dig_o;

    logic [AEC_RES_W-1:0] head;
    logic                 head_neg;
    logic [AEC_RES_W-1:0] conv_in;
    logic                 conv_done;
    logic [3:0]           conv_h;
    logic [3:0]           conv_t;
    logic [3:0]           conv_o;
    logic [1:0]           conv_first;
    logic [1:0]           emit_next;

    // Full is judged on the registered count, so a same-cycle pop cannot rescue a push.
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = (state == ST_IDLE) && !empty;
    assign head  = fifo_mem[rd_ptr];

`ifdef AEC_FMT_SIGNED_EN
    assign head_neg = head[AEC_RES_W-1];
    assign conv_in  = head_neg ? AEC_RES_W'(-head) : head;
`else
    assign head_neg = 1'b0;
    assign conv_in  = head;
`endif

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= bus.in_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (bus.in_valid && full)
                overflow_r <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    aec_bin2bcd u_bin2bcd (
        .clk      (clk),
        .rst      (rst),
        .start    (pop),
        .bin      (conv_in),
        .done     (conv_done),
        .hundreds (conv_h),
        .tens     (conv_t),
        .ones     (conv_o)
    );

    assign conv_first = first_digit(conv_h, conv_t);
    // After the sign, skip straight to the first significant digit.
    assign emit_next  = (idx == 2'd0) ? first_digit(dig_h, dig_t) : idx + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_char_r  <= 8'h00;
            neg_r       <= 1'b0;
            idx         <= 2'd0;
            dig_h       <= 4'd0;
            dig_t       <= 4'd0;
            dig_o       <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        neg_r <= head_neg;
                        state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        dig_h       <= conv_h;
                        dig_t       <= conv_t;
                        dig_o       <= conv_o;
                        out_valid_r <= 1'b1;
                        if (neg_r) begin
                            idx        <= 2'd0;
                            out_char_r <= ASCII_MINUS;
                        end else begin
                            idx        <= conv_first;
                            out_char_r <= slot_char(conv_first, conv_h, conv_t, conv_o);
                        end
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (bus.out_ready) begin
                        if (idx == 2'd3) begin
                            out_char_r <= TERM_CHAR;
                            state      <= ST_TERM;
                        end else begin
                            idx        <= emit_next;
                            out_char_r <= slot_char(emit_next, dig_h, dig_t, dig_o);
                        end
                    end
                end
                ST_TERM: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_char  = out_char_r;
    assign bus.overflow  = overflow_r;
    assign bus.busy      = !empty || (state != ST_IDLE);

endmodule

// File: tb/tb_aec_result_fmt.sv
// Directed bench for aec_result_fmt: expected bytes are queued when a result is
// sent and checked by a monitor on every handshake transfer.
module tb_aec_result_fmt;

    logic clk = 1'b0;
    logic rst;
    aec_result_fmt_if bus();

    aec_result_fmt #(.FIFO_DEPTH(4), .TERM_CHAR(8'h0A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int lf_seen    = 0;
    logic [7:0] exp_q[$];
    logic [7:0] tmp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decimal rendering built with integer arithmetic.
    task automatic model_bytes(input logic [6:0] v);
        int val;
        tmp_q.delete();
`ifdef AEC_FMT_SIGNED_EN
        val = v[6] ? int'(v) - 128 : int'(v);
`else
        val = int'(v);
`endif
        if (val < 0) begin
            tmp_q.push_back(8'h2D);
            val = -val;
        end
        if (val >= 100) tmp_q.push_back(8'(8'h30 + val / 100));
        if (val >= 10)  tmp_q.push_back(8'(8'h30 + (val / 10) % 10));
        tmp_q.push_back(8'(8'h30 + val % 10));
        tmp_q.push_back(8'h0A);
    endtask

    task automatic expect_all(input logic [6:0] v);
        model_bytes(v);
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
    endtask

    task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Pulse in_valid for one cycle and count edges until the first byte is presented.
    task automatic send_and_time(input logic [6:0] v, input string tag);
        int edges;
        bus.in_valid  = 1'b1;
        bus.in_result = v;
        tick();
        bus.in_valid  = 1'b0;
        edges = 0;
        while (bus.out_valid !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        // in_valid in cycle N -> out_valid first high in cycle N+9.
        check1({tag, "_latency"}, edges, 8);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 300) begin
            tick();
            n++;
        end
        check1({tag, "_queue_left"}, exp_q.size(), 0);
        check1({tag, "_busy_end"}, bus.busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            logic [7:0] want;
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL extra_byte: observed %02h expected none", bus.out_char);
            end
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                compared++;
                assert (bus.out_char === want) else begin
                    mismatched++;
                    $error("FAIL stream_byte: observed %02h expected %02h", bus.out_char, want);
                end
            end
            if (bus.out_char === 8'h0A) lf_seen++;
        end
    end

    initial begin
        int lf_before;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check1("rst_out_char", bus.out_char, 8'h00);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_overflow", bus.overflow, 1'b0);
        rst = 1'b0;
        tick();

        // Zero renders as a single '0'.
        bus.out_ready = 1'b1;
        expect_all(7'd0);
        send_and_time(7'd0, "zero");
        drain("zero");

        // Maximum value streams back to back with ready held high.
        expect_all(7'd127);
        send_and_time(7'd127, "max");
        for (int k = 1; k < tmp_q.size(); k++) begin
            tick();
            check1("max_consecutive", bus.out_valid, 1'b1);
        end
        tick();
        check1("max_after_term", bus.out_valid, 1'b0);
        drain("max");

        // Embedded zero must be kept.
        expect_all(7'd40);
        send_and_time(7'd40, "forty");
        drain("forty");

        // Backpressure holds the presented byte stable.
        bus.out_ready = 1'b0;
        expect_all(7'd5);
        send_and_time(7'd5, "stall");
        for (int k = 0; k < 3; k++) begin
            check1("stall_valid", bus.out_valid, 1'b1);
            check1("stall_char", bus.out_char, 8'h35);
            tick();
        end
        bus.out_ready = 1'b1;
        drain("stall");

        // Six back-to-back results while stalled: the head pops at once, 4 fill the FIFO, the 6th drops.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) expect_all(7'(i));
        lf_before = lf_seen;
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = 7'(i);
            tick();
            check1("ovf_flag", bus.overflow, (i == 6) ? 1'b1 : 1'b0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("ovf");
        check1("ovf_dropped", 6 - (lf_seen - lf_before), 1);
        check1("ovf_sticky", bus.overflow, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("ovf_cleared", bus.overflow, 1'b0);

`ifdef AEC_FMT_SIGNED_EN
        expect_all(7'h7F);
        send_and_time(7'h7F, "neg1");
        drain("neg1");
        expect_all(7'h40);
        send_and_time(7'h40, "neg64");
        drain("neg64");
`endif

        // Reset after the first byte transfers: the rest of the number and the terminator vanish.
        bus.out_ready = 1'b1;
        model_bytes(7'd127);
        exp_q.push_back(tmp_q[0]);
        send_and_time(7'd127, "abort");
        tick();
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        check1("abort_valid", bus.out_valid, 1'b0);
        check1("abort_busy", bus.busy, 1'b0);
        check1("abort_queue", exp_q.size(), 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        expect_all(7'd9);
        send_and_time(7'd9, "after_abort");
        drain("after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
